// File: rtl/bufmem_portb_ctrl_if.sv
// Port bundle for the SysClk side of one buffermem SPI buffer.
// slave  : the port-B controller.
// master : its surroundings, i.e. the host requesters plus buffermem port B.
interface bufmem_portb_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              fill_start;
  logic              fill_busy;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  fill_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout,
    output fill_busy, wr_ack, rd_ack, rd_valid, rd_data, mem_we, mem_addr, mem_din
  );

  modport master (
    output fill_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout,
    input  fill_busy, wr_ack, rd_ack, rd_valid, rd_data, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/bufmem_portb_ctrl.sv
// Port-B controller for one buffermem SPI buffer (SysClk domain).
// After reset the whole buffer is filled with FILL_PATTERN, then the port is
// shared round-robin between a host write requester and a host read requester.
// Optional build macro BUFMEM_FILL_INVERT_EN: odd addresses are filled with
// ~FILL_PATTERN instead of FILL_PATTERN.
//
// state   | meaning
// ST_FILL | writing the fill word to every address, fill_busy high
// ST_IDLE | arbitrating host write/read requests, fill_start restarts a fill
module bufmem_portb_ctrl #(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] FILL_PATTERN = 32'h5A6C_C6A5
) (
  input  logic                   SysClk,
  input  logic                   Reset,
  bufmem_portb_ctrl_if.slave     bus
);

  typedef enum logic {ST_FILL, ST_IDLE} state_t;
  typedef enum logic {RR_WR, RR_RD} rr_t;

  state_t            state;
  rr_t               rr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic              fill_busy_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic              rd_pend;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] fill_word;
  logic              wr_ok;
  logic              rd_ok;
  logic              grant_wr;
  logic              grant_rd;

`ifdef BUFMEM_FILL_INVERT_EN
  assign fill_word = fill_cnt[0] ? ~FILL_PATTERN : FILL_PATTERN;
`else
  assign fill_word = FILL_PATTERN;
`endif

  // A side acked this cycle was granted last cycle; its req is stale, so mask it.
  assign wr_ok    = bus.wr_req && !wr_ack_q;
  assign rd_ok    = bus.rd_req && !rd_ack_q;
  assign grant_wr = wr_ok && (!rd_ok || (rr_ptr == RR_WR));
  assign grant_rd = rd_ok && !grant_wr;

  // Fill sequencer, arbiter and read-return pipeline; every output registered.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state       <= ST_FILL;
      rr_ptr      <= RR_WR;
      fill_cnt    <= '0;
      fill_busy_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_pend     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      // Read address is on addrb while rd_ack is high; doutb follows one cycle later.
      rd_pend    <= rd_ack_q;
      rd_valid_q <= rd_pend;
      if (rd_pend) begin
        rd_data_q <= bus.mem_dout;
      end

      case (state)
        ST_FILL: begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= fill_cnt;
          mem_din_q  <= fill_word;
          fill_cnt   <= fill_cnt + ADDR_W'(1);
          if (&fill_cnt) begin
            state       <= ST_IDLE;
            fill_busy_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.fill_start) begin
            state       <= ST_FILL;
            fill_cnt    <= '0;
            fill_busy_q <= 1'b1;
          end else if (grant_wr) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= bus.wr_addr;
            mem_din_q  <= bus.wr_data;
            wr_ack_q   <= 1'b1;
            rr_ptr     <= RR_RD;
          end else if (grant_rd) begin
            mem_addr_q <= bus.rd_addr;
            rd_ack_q   <= 1'b1;
            rr_ptr     <= RR_WR;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.fill_busy = fill_busy_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_bufmem_portb_ctrl.sv
// Bench for bufmem_portb_ctrl: fills, directed accesses, round-robin,
// fill_start vs write, resets mid-read / mid-fill, and a random request phase
// scored against a word-level memory image of the buffer.
module tb_bufmem_portb_ctrl;
  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] PAT    = 32'h5A6C_C6A5;
`ifdef BUFMEM_FILL_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic SysClk = 1'b0;
  logic Reset  = 1'b1;
  always #5 SysClk = ~SysClk;

  bufmem_portb_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bufmem_portb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FILL_PATTERN(PAT)) dut (
    .SysClk (SysClk),
    .Reset  (Reset),
    .bus    (bus)
  );

  // buffermem port B: synchronous, write-first
  logic [31:0] ram [DEPTH];
  always @(posedge SysClk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= bus.mem_we ? bus.mem_din : ram[bus.mem_addr];
  end

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat_at(input logic [ADDR_W-1:0] a);
    return (INV_EN && a[0]) ? ~PAT : PAT;
  endfunction

  // expected buffer contents and scoreboard state
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] rdq_data [$];
  int          rdq_cyc [$];
  int          ack_log [$];
  int cyc = 0, n_wr_ack = 0, n_rd_ack = 0;
  int n_double = 0, n_spurious = 0, n_proto = 0, n_stray = 0;
  int last_wr_ack_cyc = 0, last_fall_cyc = 0;
  logic busy_prev = 1'b1;

  initial begin : monitor
    forever begin
      @(negedge SysClk);
      cyc++;
      if (Reset) begin
        rdq_data.delete();
        rdq_cyc.delete();
      end else begin
        if (bus.wr_ack && bus.rd_ack) n_double++;
        if (bus.mem_we && !bus.wr_ack && !busy_prev) n_stray++;
        if (busy_prev && !bus.fill_busy) last_fall_cyc = cyc;
        if (bus.rd_valid) begin
          if (rdq_data.size() == 0) n_spurious++;
          else begin
            logic [31:0] d;
            int c;
            d = rdq_data.pop_front();
            c = rdq_cyc.pop_front();
            check_val("rd_data", bus.rd_data, d);
            check_val("rd_latency", 32'(cyc - c), 32'd2);
          end
        end
        if (bus.wr_ack) begin
          n_wr_ack++;
          ack_log.push_back(0);
          last_wr_ack_cyc = cyc;
          if (!bus.wr_req) n_proto++;
          check_val("wr_mem_we", 32'(bus.mem_we), 32'd1);
          check_val("wr_mem_addr", 32'(bus.mem_addr), 32'(bus.wr_addr));
          check_val("wr_mem_din", bus.mem_din, bus.wr_data);
          exp_mem[bus.wr_addr] = bus.wr_data;
        end
        if (bus.rd_ack) begin
          n_rd_ack++;
          ack_log.push_back(1);
          if (!bus.rd_req) n_proto++;
          check_val("rd_mem_we", 32'(bus.mem_we), 32'd0);
          check_val("rd_mem_addr", 32'(bus.mem_addr), 32'(bus.rd_addr));
          rdq_data.push_back(exp_mem[bus.rd_addr]);
          rdq_cyc.push_back(cyc);
        end
      end
      busy_prev = bus.fill_busy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr_txn(input logic [ADDR_W-1:0] a, input logic [31:0] d, input int limit);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    while (!got && n < limit) begin
      @(negedge SysClk);
      n++;
      got = bus.wr_ack;
    end
    check_val("wr_ack_seen", 32'(got), 32'd1);
    @(posedge SysClk); #1;
    bus.wr_req = 1'b0;
  endtask

  task automatic rd_txn(input logic [ADDR_W-1:0] a, input int limit);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    while (!got && n < limit) begin
      @(negedge SysClk);
      n++;
      got = bus.rd_ack;
    end
    check_val("rd_ack_seen", 32'(got), 32'd1);
    @(posedge SysClk); #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    int n;
    rd_txn(a, 20);
    n = 0;
    do begin
      @(negedge SysClk);
      n++;
    end while (!bus.rd_valid && n < 6);
    check_val({tag, "_data"}, bus.rd_data, exp);
    check_val({tag, "_ack_to_valid"}, 32'(n), 32'd2);
  endtask

  // Expected: fill_busy high for DEPTH cycles, DEPTH writes to 0..DEPTH-1 in order.
  task automatic fill_check(input string tag);
    int busy_n, wr_n, bad;
    logic busy;
    busy_n = 0;
    wr_n = 0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat_at(ADDR_W'(i));
    do begin
      @(negedge SysClk);
      busy = bus.fill_busy;
      if (busy) busy_n++;
      if (bus.mem_we && !bus.wr_ack) begin
        if (bus.mem_addr !== ADDR_W'(wr_n) || bus.mem_din !== pat_at(ADDR_W'(wr_n))) bad++;
        wr_n++;
      end
    end while (busy && busy_n < DEPTH + 50);
    check_val({tag, "_busy_len"}, 32'(busy_n), 32'(DEPTH));
    check_val({tag, "_writes"}, 32'(wr_n), 32'(DEPTH));
    check_val({tag, "_bad_words"}, 32'(bad), 32'd0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 7));
    return (k == 7) ? '1 : ADDR_W'(k);
  endfunction

  initial begin : main
    int n0, n, seq;
    logic found;
    bus.fill_start = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;

    // reset values
    repeat (3) @(posedge SysClk);
    @(negedge SysClk);
    check_val("rst_fill_busy", 32'(bus.fill_busy), 32'd1);
    check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("rst_mem_din", bus.mem_din, 32'd0);
    check_val("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check_val("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("rst_rd_data", bus.rd_data, 32'd0);

    @(posedge SysClk); #1;
    Reset = 1'b0;
    fill_check("fill0");
    @(negedge SysClk);
    check_val("idle_mem_we", 32'(bus.mem_we), 32'd0);
    @(posedge SysClk); #1;

    // fill content, including the odd/even rule
    rd_expect("fill_rd1", 10'h001, pat_at(10'h001));
    rd_expect("fill_rd2", 10'h002, pat_at(10'h002));

    // write then read back
    n0 = n_wr_ack;
    wr_txn(10'h012, 32'hDEAD_BEEF, 20);
    rd_expect("raw_012", 10'h012, 32'hDEAD_BEEF);
    check_val("raw_wr_ack_pulses", 32'(n_wr_ack - n0), 32'd1);

    // both requesters held and reissuing: W,R,W,R,...
    ack_log.delete();
    n0 = n_double;
    fork
      for (int i = 0; i < 4; i++) wr_txn(ADDR_W'(32 + i), $urandom, 20);
      for (int j = 0; j < 4; j++) rd_txn(ADDR_W'(32 + j), 20);
    join
    repeat (4) @(posedge SysClk); #1;
    check_val("rr_grants", 32'(ack_log.size()), 32'd8);
    seq = 0;
    for (int k = 0; k < ack_log.size() && k < 8; k++) seq = seq | (ack_log[k] << k);
    check_val("rr_order", 32'(seq), 32'h0000_00AA);
    check_val("rr_double_ack", 32'(n_double - n0), 32'd0);

    // random requesters
    fork
      for (int i = 0; i < 150; i++) begin
        int g;
        g = int'($urandom_range(0, 2));
        if (g > 0) begin repeat (g) @(posedge SysClk); #1; end
        wr_txn(rand_addr(), $urandom, 40);
      end
      for (int j = 0; j < 150; j++) begin
        int h;
        h = int'($urandom_range(0, 2));
        if (h > 0) begin repeat (h) @(posedge SysClk); #1; end
        rd_txn(rand_addr(), 40);
      end
    join
    repeat (6) @(posedge SysClk); #1;

    // fill_start beats a same-cycle write request
    n0 = n_wr_ack;
    bus.fill_start = 1'b1;
    bus.wr_addr = 10'h033;
    bus.wr_data = 32'h1234_5678;
    bus.wr_req = 1'b1;
    @(posedge SysClk); #1;
    bus.fill_start = 1'b0;
    fill_check("fs");
    n = 0;
    do begin
      @(negedge SysClk);
      n++;
    end while (!bus.wr_ack && n < 5);
    @(posedge SysClk); #1;
    bus.wr_req = 1'b0;
    repeat (2) @(posedge SysClk); #1;
    check_val("fs_wr_acks", 32'(n_wr_ack - n0), 32'd1);
    check_val("fs_ack_after_fall", 32'(last_wr_ack_cyc - last_fall_cyc), 32'd1);
    rd_expect("fs_rd_033", 10'h033, 32'h1234_5678);
    rd_expect("fs_rd_012", 10'h012, pat_at(10'h012));

    // reset while a read is in flight: no rd_valid, fill restarts
    bus.rd_addr = 10'h005;
    bus.rd_req = 1'b1;
    n = 0;
    do begin
      @(negedge SysClk);
      n++;
    end while (!bus.rd_ack && n < 10);
    check_val("rstrd_ack_seen", 32'(bus.rd_ack), 32'd1);
    @(posedge SysClk); #1;
    bus.rd_req = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge SysClk); #1;
    Reset = 1'b0;
    fill_check("rst_rd");

    // reset at fill address 0x200
    @(posedge SysClk); #1;
    bus.fill_start = 1'b1;
    @(posedge SysClk); #1;
    bus.fill_start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < DEPTH + 50) begin
      @(negedge SysClk);
      n++;
      found = bus.mem_we && (bus.mem_addr == 10'h200);
    end
    check_val("midfill_reached_200", 32'(found), 32'd1);
    @(posedge SysClk); #1;
    Reset = 1'b1;
    @(negedge SysClk);
    check_val("midfill_rst_busy", 32'(bus.fill_busy), 32'd1);
    @(posedge SysClk); #1;
    Reset = 1'b0;
    fill_check("refill");
    rd_expect("refill_rd_3ff", 10'h3FF, pat_at(10'h3FF));

    repeat (4) @(posedge SysClk); #1;
    check_val("double_acks", 32'(n_double), 32'd0);
    check_val("spurious_rd_valid", 32'(n_spurious), 32'd0);
    check_val("ack_without_req", 32'(n_proto), 32'd0);
    check_val("stray_mem_we", 32'(n_stray), 32'd0);
    check_val("reads_outstanding", 32'(rdq_data.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule

// File: doc/bufmem_portb_ctrl.md
Name: bufmem_portb_ctrl

Overview:
- Owns the SysClk-side 32-bit port of one buffermem SPI buffer.
- After reset, it fills the buffer with a pattern.
- After the fill, it shares the port between a host write requester and a host read requester using round-robin arbitration.
- Sits between system logic and buffermem port B; the SPI clock side (spiifc) is untouched.

Parameters:
- ADDR_W, 10, word address width; buffer depth is 2^ADDR_W 32-bit words.
- DATA_W, 32, port data width.
- FILL_PATTERN, 32'h5A6C_C6A5, word written during a fill.

Ports:
- SysClk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- fill_start  in  1  one-cycle pulse; restarts a full-buffer fill (honoured only in IDLE).
- fill_busy  out  1  high while a fill is in progress.
- wr_req  in  1  write request, level; held until wr_ack.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse; write issued to memory this cycle.
- rd_req  in  1  read request, level; held until rd_ack.
- rd_addr  in  ADDR_W  read word address.
- rd_ack  out  1  one-cycle pulse; read address issued this cycle.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  DATA_W  registered read data.
- mem_we  out  1  port write enable (to buffermem web).
- mem_addr  out  ADDR_W  port address (to addrb).
- mem_din  out  DATA_W  port write data (to dinb).
- mem_dout  in  DATA_W  port read data (from doutb); 1-cycle synchronous latency.

Behaviour:
- Reset values (all outputs registered): fill_busy=1, mem_we=0, mem_addr=0, mem_din=0, wr_ack=0, rd_ack=0, rd_valid=0, rd_data=0. State=FILL, fill counter=0, RR pointer=WR.
- Reset asserted mid-fill or mid-read: fill restarts from address 0; the in-flight read is discarded and no rd_valid is issued.
- States: FILL, IDLE.
- FILL:
  - Each cycle: mem_we=1, mem_addr=count, mem_din=FILL_PATTERN; count increments.
  - Runs 2^ADDR_W consecutive cycles, starting the first cycle after Reset deasserts.
  - After address 2^ADDR_W-1 is written: fill_busy falls and the state moves to IDLE.
  - No wr_ack or rd_ack is issued during FILL; requests simply stay pending.
  - fill_start is ignored during FILL.
- IDLE, evaluated in priority order each cycle:
  - fill_start=1: enter FILL, count=0, fill_busy=1 next cycle. fill_start beats any pending request, and that cycle issues no ack.
  - Only wr_req: grant write.
  - Only rd_req: grant read.
  - Both: grant the side named by the RR pointer; the pointer then flips to the other side. Any single grant sets the pointer to the non-granted side.
- Write grant (cycle N registers):
  - mem_we=1, mem_addr=wr_addr, mem_din=wr_data, and wr_ack=1, all visible in cycle N+1.
  - mem_we is 0 in every cycle without a write or fill.
- Read grant (cycle N registers):
  - mem_addr=rd_addr, mem_we=0, rd_ack=1, visible in cycle N+1.
  - mem_dout is valid in N+2 and captured into rd_data; rd_valid=1 in N+3.
- Throughput:
  - At most one grant per cycle.
  - Back-to-back grants are allowed; reads are pipelined and multiple reads may be in flight.
  - The requester deasserts req the cycle after seeing ack. A req still high in that cycle counts as a new request.
  - Because acks are registered, the arbiter masks the side it granted in the previous cycle. This prevents a double grant from a stale req.
- Read-after-write to the same address in consecutive grants returns the new data (BRAM write-first on port B).
- Addresses wrap naturally at ADDR_W bits; there is no bounds error.

Optional Feature:
- Macro: BUFMEM_FILL_INVERT_EN.
- Defined: during FILL, words at odd addresses are written as ~FILL_PATTERN; even addresses get FILL_PATTERN.
- Undefined: every word is FILL_PATTERN.

Test Plan:
- Reset 1 cycle, then release -> fill_busy high exactly 1024 cycles; mem_we=1 on addresses 0..0x3FF with data 0x5A6C_C6A5; then IDLE, mem_we=0.
- After fill, wr_req addr 0x012 data 0xDEAD_BEEF, then rd_req addr 0x012 -> wr_ack one pulse; rd_ack then rd_valid 2 cycles later with rd_data=0xDEAD_BEEF.
- wr_req and rd_req held high together with requesters reissuing 4 times each -> grants alternate W,R,W,R..., no side starved, no double ack.
- fill_start pulsed in the same cycle as wr_req -> no wr_ack; a new 1024-cycle fill runs; wr_ack is issued the cycle after fill_busy falls.
- Reset asserted at fill address 0x200 -> after release, fill restarts at 0x000 and runs 1024 cycles.
- BUFMEM_FILL_INVERT_EN defined -> read addr 0x001 returns 0xA593_395A; read addr 0x002 returns 0x5A6C_C6A5.
